sevenseg_scan: RTL and testbench
================================

// Module: sevenseg_scan
// PURPOSE
//  Time-multiplexed driver for NUM_DIGITS hex seven-segment digits sharing one segment bus.
//  Holds a double-buffered display value and scans digits one at a time via per-digit enables.
//  New values are committed only at frame boundaries, so the display never tears.
//  Sits between the datapath (value producer) and the board pins, replacing per-digit decoders.
// PARAMETERS
//  NUM_DIGITS   4   digits driven, legal 1..8; digit 0 = value[3:0] (least significant)
//  SCAN_DIV     4   clk cycles each digit stays enabled, legal >= 2
//  SEG_ACT_LOW  0   1: segments/dp driven active-low at pins; 0: active-high
//  AN_ACT_LOW   1   1: digit enables active-low; 0: active-high
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               synchronous, active-high
//  load         in   1               capture value/dp_in into shadow register this cycle
//  value        in   4*NUM_DIGITS    hex nibbles, nibble i shown on digit i
//  dp_in        in   NUM_DIGITS      decimal point per digit, 1 = lit
//  pending      out  1               shadow holds a value not yet committed to display
//  segments     out  7               {a,b,c,d,e,f,g}, bit 6 = a
//  dp           out  1               decimal point of current digit
//  anodes       out  NUM_DIGITS      one-hot digit enable (polarity per AN_ACT_LOW)
//  frame_start  out  1               1-cycle pulse on the cycle digit 0 output becomes active
// BEHAVIOUR
//  - One clock, synchronous active-high reset; all outputs registered.
//  - Reset: prescaler=0, digit index=0, active=0, shadow=0, pending=0; segments/dp all off
//    (inactive level), anodes all inactive, frame_start=0. Mid-operation reset has the same effect.
//  - Prescaler counts 0..SCAN_DIV-1; tick when it equals SCAN_DIV-1, then wraps to 0.
//  - On tick: index += 1; at NUM_DIGITS-1 wrap to 0 (= frame boundary, "commit").
//  - Output registers load from index/active one cycle after index changes (latency 1).
//    The first cycle after reset deasserts drives digit 0 with active=0 (glyph '0');
//    frame_start pulses on that cycle and on every cycle digit 0 output begins.
//  - Each digit is enabled exactly SCAN_DIV cycles; one frame = NUM_DIGITS*SCAN_DIV cycles.
//    Exactly one anode is active at any time after reset.
//  - load: shadow <= {value,dp_in}, pending <= 1. A load while pending overwrites (last wins).
//  - Commit: if pending at wrap, active <= shadow, pending <= 0.
//    load in the same cycle as commit: active <= value/dp_in directly, pending <= 0.
//  - NUM_DIGITS=1: every tick is a commit; only anodes[0] is ever active.
//  - Glyphs (active-high, before polarity): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B
//    A:77 b:1F C:4E d:3D E:4F F:47. SEG_ACT_LOW inverts segments and dp at the output register.
// CONFIGURATION
//  SEVENSEG_SCAN_LZB_EN defined: leading-zero blanking. Digits above the most significant
//    nonzero nibble of active show segments off (dp still honoured, anode still scanned).
//    Digit 0 is never blanked (active=0 shows '0').
//  Undefined: every digit shows its glyph; no blanking logic is synthesised.
// TESTING
//  1 reset held 3 cycles -> anodes inactive, segments off, pending=0; release -> digit 0
//    shows 7E, frame_start=1 for one cycle.
//  2 NUM_DIGITS=4, SCAN_DIV=4 -> each anode active 4 cycles in order 0,1,2,3, frame_start
//    every 16 cycles, never 0 or 2 anodes active.
//  3 load value=16'h12AF mid-frame -> pending=1 until wrap, display unchanged; next frame
//    digits 0..3 = 47,77,6D,30; pending=0.
//  4 load 16'h1111 then 16'h2222 before wrap -> only 6D shown on all digits;
//    a load on the commit cycle is displayed in the frame that starts.
//  5 SEVENSEG_SCAN_LZB_EN, value=16'h0050, dp_in=4'b1000 -> digit0 7E, digit1 5B,
//    digit2 off, digit3 segments off with dp lit; without macro digits 2,3 show 7E.
//  6 assert reset mid-frame with pending=1 -> next cycle all state cleared, pending=0,
//    scan restarts at digit 0 showing '0'.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex seven-segment scanner with a frame-synchronous double-buffered value.
// Define SEVENSEG_SCAN_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module sevenseg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 4,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    pending,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACT_LOW}};
  localparam logic                  DP_OFF   = SEG_ACT_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACT_LOW}};

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_fs;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp_cur;
  logic                    w_blank;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_an_onehot;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h00;
    case (n)
      4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
      4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
      4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  4'hF: g = 7'h47;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign w_tick = (r_presc == PRE_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A load coinciding with the frame wrap bypasses the shadow so it shows in the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_pending    <= 1'b0;
    end else if (load && w_wrap) begin
      r_shadow_val <= value;
      r_shadow_dp  <= dp_in;
      r_act_val    <= value;
      r_act_dp     <= dp_in;
      r_pending    <= 1'b0;
    end else if (load) begin
      r_shadow_val <= value;
      r_shadow_dp  <= dp_in;
      r_pending    <= 1'b1;
    end else if (w_wrap && r_pending) begin
      r_act_val    <= r_shadow_val;
      r_act_dp     <= r_shadow_dp;
      r_pending    <= 1'b0;
    end
  end

  assign w_nib    = r_act_val[{r_idx, 2'b00} +: 4];
  assign w_dp_cur = r_act_dp[r_idx];
  assign w_glyph  = hex_glyph(w_nib);

`ifdef SEVENSEG_SCAN_LZB_EN
  logic w_upper_zero;
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= r_idx) && (r_act_val[4*i +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
  end
  assign w_blank = (r_idx != '0) && w_upper_zero;
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_an_onehot        = '0;
    w_an_onehot[r_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
      r_fs  <= 1'b0;
    end else begin
      r_seg <= (w_blank ? 7'h00 : w_glyph) ^ SEG_OFF;
      r_dp  <= w_dp_cur ^ DP_OFF;
      r_an  <= w_an_onehot ^ AN_OFF;
      r_fs  <= (r_idx == '0) && (r_presc == '0);
    end
  end

  assign pending     = r_pending;
  assign segments    = r_seg;
  assign dp          = r_dp;
  assign anodes      = r_an;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a cycle-count reference model pushes the expected
// pin state for every clock; a negedge monitor pops and compares.
module tb_sevenseg_scan;
  localparam int N        = 4;
  localparam int D        = 4;
  localparam int FRAME    = N * D;
  localparam bit SEG_LOW  = 1'b0;
  localparam bit AN_LOW   = 1'b1;

  logic           clk;
  logic           reset;
  logic           load;
  logic [4*N-1:0] value;
  logic [N-1:0]   dp_in;
  logic           pending;
  logic [6:0]     segments;
  logic           dp;
  logic [N-1:0]   anodes;
  logic           frame_start;

  sevenseg_scan #(
    .NUM_DIGITS(N), .SCAN_DIV(D), .SEG_ACT_LOW(SEG_LOW), .AN_ACT_LOW(AN_LOW)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .pending(pending), .segments(segments), .dp(dp), .anodes(anodes),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         fs;
    logic         pend;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] glyph_tbl [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model: position in the scan follows purely from cycles since reset release.
  int             m_c = 0;
  logic [4*N-1:0] m_act_val = '0;
  logic [N-1:0]   m_act_dp  = '0;
  logic [4*N-1:0] m_sh_val  = '0;
  logic [N-1:0]   m_sh_dp   = '0;
  bit             m_pend    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit ld, input logic [4*N-1:0] v, input logic [N-1:0] d);
    exp_t       e;
    int         dig;
    logic [6:0] g;
    logic [N-1:0] oh;
    @(negedge clk);
    #1;
    reset = rst; load = ld; value = v; dp_in = d;
    if (rst) begin
      e.an = {N{AN_LOW}}; e.seg = {7{SEG_LOW}}; e.dp = SEG_LOW; e.fs = 1'b0; e.pend = 1'b0;
      m_c = 0; m_act_val = '0; m_act_dp = '0; m_sh_val = '0; m_sh_dp = '0; m_pend = 1'b0;
    end else begin
      dig = (m_c / D) % N;
      g = glyph_tbl[m_act_val[4*dig +: 4]];
`ifdef SEVENSEG_SCAN_LZB_EN
      if (dig > 0 && (m_act_val >> (4*dig)) == '0) g = 7'h00;
`endif
      oh = '0;
      oh[dig] = 1'b1;
      e.an  = oh ^ {N{AN_LOW}};
      e.seg = g ^ {7{SEG_LOW}};
      e.dp  = m_act_dp[dig] ^ SEG_LOW;
      e.fs  = ((m_c % FRAME) == 0);
      if (ld) begin m_sh_val = v; m_sh_dp = d; m_pend = 1'b1; end
      if ((m_c % FRAME) == FRAME - 1 && m_pend) begin
        m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_pend = 1'b0;
      end
      e.pend = m_pend;
      m_c++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, (4*N)'($urandom), N'($urandom));
  endtask

  task automatic idle_until(input int phase);
    while ((m_c % FRAME) != phase) idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("anodes",      32'(anodes),      32'(e.an));
      chk("segments",    32'(segments),    32'(e.seg));
      chk("dp",          32'(dp),          32'(e.dp));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("pending",     32'(pending),     32'(e.pend));
    end
  end

  initial begin
    int r;
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0;

    repeat (3) drive(1'b1, 1'b0, '0, '0);
    repeat (2 * FRAME + 5) idle();

    idle_until(6);
    drive(1'b0, 1'b1, 16'h12AF, 4'b0000);
    repeat (2 * FRAME) idle();

    idle_until(3);
    drive(1'b0, 1'b1, 16'h1111, 4'b0001);
    repeat (2) idle();
    drive(1'b0, 1'b1, 16'h2222, 4'b0000);
    repeat (FRAME) idle();

    idle_until(FRAME - 1);
    drive(1'b0, 1'b1, 16'h3C4D, 4'b0101);
    repeat (FRAME) idle();

    idle_until(8);
    drive(1'b0, 1'b1, 16'h0050, 4'b1000);
    repeat (2 * FRAME) idle();

    idle_until(5);
    drive(1'b0, 1'b1, 16'h0000, 4'b0000);
    repeat (2 * FRAME) idle();

    idle_until(9);
    drive(1'b0, 1'b1, 16'hBEEF, 4'b0110);
    idle();
    drive(1'b1, 1'b1, 16'h7777, 4'b1111);
    repeat (FRAME + 3) idle();

    repeat (800) begin
      r = $urandom_range(0, 199);
      if (r == 0)       drive(1'b1, 1'b0, '0, '0);
      else if (r < 30)  drive(1'b0, 1'b1, (4*N)'($urandom), N'($urandom));
      else              idle();
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
